load_store_buffer: RTL
======================

# load_store_buffer

In-order load/store queue that sits between Dispatch, the ROB and the memory controller in the Tomasulo RISC-V core. It accepts dispatched memory instructions and captures missing operands from the ROB's ALU/load broadcasts. It issues loads as soon as their base register is known, writes stores to memory only after the ROB commits them, and returns load data to the ROB. It is the responder to the ROB's store-commit, head and update interfaces.

## Interface
- DEPTH, 16, queue entries (power of two)
- ROB_W, 4, reorder tag width
- IO_BASE, 32'h0003_0000, addresses >= this are I/O; I/O loads are non-speculative
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds and result pulses are forced low
- clr  in  1  ROB flush (misprediction or jump)
- full  out  1  registered; high when a dispatch next cycle could overflow
- disp_s, disp_op[3:0], disp_reorder[ROB_W-1:0], disp_imm[31:0]  in  dispatch an entry
- disp_rs1_rdy, disp_rs1_val[31:0], disp_rs1_tag[ROB_W-1:0]  in  base operand value or tag
- disp_rs2_rdy, disp_rs2_val[31:0], disp_rs2_tag[ROB_W-1:0]  in  store-data operand value or tag
- upd1_s/upd1_reorder/upd1_val, upd2_s/upd2_reorder/upd2_val  in  ROB broadcasts (ALU, load)
- store_s, store_reorder[ROB_W-1:0]  in  ROB commits the store carrying this tag
- rob_head_s, rob_head[ROB_W-1:0]  in  ROB head tag valid / tag
- load_s, load_reorder, load_val[31:0]  out  one-cycle load result pulse to the ROB
- mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_size[1:0]  out  memory request
- mem_done  in  1  one-cycle completion; mem_rdata[31:0]  in  raw little-endian data

## Operation
- Circular queue head/tail pointers plus count; per entry: op, reorder, rs1/rs2 value+ready+tag, imm, committed.
- Dispatch: written at tail; an operand whose tag matches upd1 or upd2 in the same cycle is captured as ready.
- Snoop: each cycle, every entry operand not ready with a tag equal to upd*_reorder takes upd*_val. Both updates apply; upd2 wins on a tag clash.
- Commit: an entry whose reorder equals store_reorder while store_s is high sets committed.
- Address is rs1_val + imm, mod 2^32. Misalignment is not checked.
- FSM IDLE -> MEM -> IDLE. Issue considers only the head entry.
  - A load issues when rs1 is ready. If the address is >= IO_BASE, it also needs rob_head_s and rob_head == reorder.
  - A store issues when rs1 and rs2 are ready and committed is set.
- MEM holds mem_req and all request fields stable until mem_done.
- On mem_done the head is popped.
  - Loads extend the data by op: LB/LH sign-extend, LBU/LHU zero-extend, LW is 32-bit.
  - The load result is driven on load_* in the next cycle.
- clr:
  - Drops every entry at and after the first uncommitted entry; committed stores survive.
  - An in-flight store completes.
  - An in-flight load completes to memory, but load_s stays low.
  - A dispatch in the clr cycle is ignored.

## Timing
- Reset values: full=0, load_s=0, mem_req=0, mem_we=0; all buses 0; FSM=IDLE; queue empty.
- Dispatch to earliest mem_req is 1 cycle: entry written at edge N, mem_req high after edge N+1.
- mem_done at edge M: load_s high for the cycle after edge M; the next request starts no earlier than edge M+1.
- Store commit to mem_req is at least 1 cycle.
- full = (count_next >= DEPTH-1), so an overflow is impossible with one dispatch per cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by count.
- Simultaneous dispatch and pop: count is unchanged.
- Dispatch while full is a protocol error; the entry is dropped.
- rst_n asserted mid-transaction: all state clears immediately; mem_req drops asynchronously.

## Structure
- Shared package holds:
  - Op encodings LB, LH, LW, LBU, LHU, SB, SH, SW
  - mem_size encodings 0=byte, 1=half, 2=word
  - The IO_BASE default, ROB_W and the Enable/Disable and True/False constants used across the core
- One sub-module, lsb_load_extend: combinational extension of mem_rdata by op.

## Test plan
- Reset then LW with rs1=0x100 ready, imm=4 -> mem_req with addr=0x104, size=2, we=0. mem_done with rdata=0xDEADBEEF -> next cycle load_s=1, load_val=0xDEADBEEF.
- LB with rdata=0x00000080 -> load_val=0xFFFFFF80. LBU with the same data -> 0x00000080.
- SW with rs1 tagged 3 and rs2 tagged 5:
  - No mem_req until upd1(3, 0x200), upd2(5, 0x55) and store_s with the store's tag.
  - Then mem_req: we=1, addr=0x200, wdata=0x55.
- Committed SB at head, uncommitted LW and SW behind it, then clr -> SB is still written, count becomes 0 afterwards, and load_s never pulses.
- Load to 0x30004 with rob_head != its tag -> no mem_req. rob_head == its tag -> request the next cycle.
- Fill the queue to 15 entries -> full=1. Pop one -> full=0. Run 40 dispatch/pop cycles -> pointers wrap and no entry is lost or duplicated.

Source files
------------

// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: op and size encodings, FSM
// states, core-wide constants and small op-decode helpers.
package load_store_buffer_pkg;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;

  localparam int          DEF_ROB_W   = 4;
  localparam logic [31:0] DEF_IO_BASE = 32'h0003_0000;

  // Bit 3 marks a store; the low two bits double as the access size.
  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } lsb_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } lsb_state_e;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic [1:0] size_of(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      default:              sz = SIZE_WORD;
    endcase
    return sz;
  endfunction
endpackage

// File: rtl/lsb_load_extend.sv
// Purpose: sign/zero extension of raw memory read data according to load op.
// Latency: combinational. Backpressure: none.
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  always_comb begin
    data = rdata;
    case (op)
      OP_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
      OP_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
      OP_LBU:  data = {24'h0, rdata[7:0]};
      OP_LHU:  data = {16'h0, rdata[15:0]};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/load_store_buffer.sv
// Purpose: in-order load/store queue between dispatch, ROB and memory.
// Latency: dispatch to mem_req 1 cycle; mem_done to load_s 1 cycle. Backpressure: registered full.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          ROB_W   = DEF_ROB_W,
  parameter logic [31:0] IO_BASE = DEF_IO_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clr,
  output logic             full,
  input  logic             disp_s,
  input  logic [3:0]       disp_op,
  input  logic [ROB_W-1:0] disp_reorder,
  input  logic [31:0]      disp_imm,
  input  logic             disp_rs1_rdy,
  input  logic [31:0]      disp_rs1_val,
  input  logic [ROB_W-1:0] disp_rs1_tag,
  input  logic             disp_rs2_rdy,
  input  logic [31:0]      disp_rs2_val,
  input  logic [ROB_W-1:0] disp_rs2_tag,
  input  logic             upd1_s,
  input  logic [ROB_W-1:0] upd1_reorder,
  input  logic [31:0]      upd1_val,
  input  logic             upd2_s,
  input  logic [ROB_W-1:0] upd2_reorder,
  input  logic [31:0]      upd2_val,
  input  logic             store_s,
  input  logic [ROB_W-1:0] store_reorder,
  input  logic             rob_head_s,
  input  logic [ROB_W-1:0] rob_head,
  output logic             load_s,
  output logic [ROB_W-1:0] load_reorder,
  output logic [31:0]      load_val,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_size,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_AT = (PW+1)'(DEPTH - 1);

  typedef struct packed {
    logic [3:0]       op;
    logic [ROB_W-1:0] reorder;
    logic             rs1_rdy;
    logic [31:0]      rs1_val;
    logic [ROB_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [31:0]      rs2_val;
    logic [ROB_W-1:0] rs2_tag;
    logic [31:0]      imm;
    logic             committed;
  } entry_t;

  entry_t           q   [DEPTH];
  entry_t           q_n [DEPTH];
  entry_t           hd, disp_e;
  logic [31:0]      hd_addr, ext_val;
  logic [PW:0]      count, count_n, keep, base;
  logic [PW-1:0]    head, tail, tail_n, idx;
  logic             issue, start, done, head_alive, push, pop, run;
  logic             kill, load_pulse;
  lsb_state_e       state, state_n;
  logic [3:0]       cur_op;
  logic [ROB_W-1:0] cur_reorder;

  assign hd      = q[head];
  assign hd_addr = hd.rs1_val + hd.imm;
  assign load_s  = load_pulse & rdy;

  // upd2 is applied last so it wins when both broadcasts carry the same tag.
  function automatic logic [32:0] snoop(input logic r, input logic [31:0] v,
                                        input logic [ROB_W-1:0] t);
    logic [32:0] res;
    res = {r, v};
    if (!r && upd1_s && t == upd1_reorder) res = {TRUE, upd1_val};
    if (!r && upd2_s && t == upd2_reorder) res = {TRUE, upd2_val};
    return res;
  endfunction

  always_comb begin
    disp_e         = '0;
    disp_e.op      = disp_op;
    disp_e.reorder = disp_reorder;
    disp_e.imm     = disp_imm;
    disp_e.rs1_tag = disp_rs1_tag;
    disp_e.rs2_tag = disp_rs2_tag;
    {disp_e.rs1_rdy, disp_e.rs1_val} = snoop(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag);
    {disp_e.rs2_rdy, disp_e.rs2_val} = snoop(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag);
    for (int i = 0; i < DEPTH; i++) begin
      q_n[i] = q[i];
      {q_n[i].rs1_rdy, q_n[i].rs1_val} = snoop(q[i].rs1_rdy, q[i].rs1_val, q[i].rs1_tag);
      {q_n[i].rs2_rdy, q_n[i].rs2_val} = snoop(q[i].rs2_rdy, q[i].rs2_val, q[i].rs2_tag);
      if (store_s && q[i].reorder == store_reorder) q_n[i].committed = TRUE;
      if (push && tail == PW'(i)) q_n[i] = disp_e;
    end
  end

  // Number of leading committed entries: what survives a flush.
  always_comb begin
    keep = '0;
    run  = TRUE;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (run && (PW+1)'(i) < count && q[idx].committed) keep = keep + 1'b1;
      else run = FALSE;
    end
  end

  always_comb begin
    issue = FALSE;
    if (count != '0) begin
      if (is_store(hd.op)) issue = hd.rs1_rdy && hd.rs2_rdy && hd.committed;
      else issue = hd.rs1_rdy &&
                   (hd_addr < IO_BASE || (rob_head_s && rob_head == hd.reorder));
      if (clr && !hd.committed) issue = FALSE;
    end
  end

  always_comb begin
    state_n = state;
    start   = FALSE;
    done    = FALSE;
    case (state)
      ST_IDLE: if (issue) begin
        state_n = ST_MEM;
        start   = TRUE;
      end
      ST_MEM: if (mem_done) begin
        state_n = ST_IDLE;
        done    = TRUE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The in-flight head is gone if an earlier flush killed it or this one does.
  assign head_alive = !kill && !(clr && keep == '0);
  assign pop        = done && head_alive;
  assign push       = disp_s && !clr && !full;
  assign base       = clr ? keep : count;
  assign count_n    = base + (PW+1)'(push) - (PW+1)'(pop);
  assign tail_n     = clr ? head + keep[PW-1:0] : tail + PW'(push);

  lsb_load_extend u_ext (
    .op    (cur_op),
    .rdata (mem_rdata),
    .data  (ext_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      state        <= ST_IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= FALSE;
      kill         <= FALSE;
      load_pulse   <= FALSE;
      load_reorder <= '0;
      load_val     <= '0;
      mem_req      <= DISABLE;
      mem_we       <= DISABLE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_size     <= '0;
      cur_op       <= '0;
      cur_reorder  <= '0;
    end else if (rdy) begin
      q          <= q_n;
      state      <= state_n;
      head       <= head + PW'(pop);
      tail       <= tail_n;
      count      <= count_n;
      full       <= (count_n >= FULL_AT);
      load_pulse <= FALSE;
      if (start) begin
        mem_req     <= ENABLE;
        mem_we      <= is_store(hd.op);
        mem_addr    <= hd_addr;
        mem_wdata   <= is_store(hd.op) ? hd.rs2_val : '0;
        mem_size    <= size_of(hd.op);
        cur_op      <= hd.op;
        cur_reorder <= hd.reorder;
      end
      if (done) begin
        mem_req <= DISABLE;
        mem_we  <= DISABLE;
        kill    <= FALSE;
        if (!is_store(cur_op) && head_alive) begin
          load_pulse   <= TRUE;
          load_reorder <= cur_reorder;
          load_val     <= ext_val;
        end
      end else if (state == ST_MEM && clr && keep == '0) begin
        kill <= TRUE;
      end
    end
  end
endmodule
